// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Consumes addresses from the PC counter and issues fixed-latency
//               reads to instruction memory. Returned words are buffered with
//               their PC in a prefetch FIFO and handed to decode over a
//               valid/ready handshake. Flush drops buffered and in-flight work.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              flush
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Wide enough to hold count + inflight without wrapping.
    localparam int SUM_W = $clog2(DEPTH + MEM_LAT + 1) + 1;

    // In-flight pipe: one valid/PC pair per cycle of memory latency.
    logic [MEM_LAT-1:0] pipe_vld_q;
    logic [ADDR_W-1:0]  pipe_pc_q [MEM_LAT];

    // Prefetch FIFO storage and control.
    logic [DATA_W-1:0]  fifo_data_q [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_q   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic [SUM_W-1:0]   inflight;
    logic               credit;
    logic               accept;
    logic               push;
    logic               pop;

    // Count in-flight reads; they already own a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + SUM_W'(pipe_vld_q[i]);
        end
    end

    assign credit    = (SUM_W'(count_q) + inflight) < SUM_W'(DEPTH);
    assign pc_ready  = rstn & ~flush & credit;
    assign accept    = pc_valid & pc_ready;
    assign imem_rd   = accept;
    assign imem_addr = pc_addr;

    // A return landing during a flush is dropped, as is a pop.
    assign push = pipe_vld_q[MEM_LAT-1] & ~flush;
    assign pop  = instr_valid & instr_ready & ~flush;

    assign instr_valid = (count_q != '0);
    assign instr_out   = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;

    // In-flight valid shift register; cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    // In-flight PC shift register; payload only, qualified by pipe_vld_q.
    always_ff @(posedge clk) begin
        pipe_pc_q[0] <= pc_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_pc_q[i] <= pipe_pc_q[i-1];
        end
    end

    // Capture returned word and its PC at the write pointer.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= pipe_pc_q[MEM_LAT-1];
        end
    end

    // FIFO pointer and occupancy next-state; push+pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Credit accounting must make a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && (count_q == CNT_W'(DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Bench for instr_fetch_unit. Two instances (memory latency 1
//               and 3, depth 4) share stimulus; each has its own memory model
//               and a transaction-level expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int LOGN   = 8192;

    logic              clk = 1'b0;
    logic              rstn;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              instr_ready;
    logic              flush;

    logic [1:0]        pc_ready;
    logic [1:0]        imem_rd;
    logic [1:0]        instr_valid;
    logic [ADDR_W-1:0] imem_addr  [2];
    logic [DATA_W-1:0] imem_rdata [2];
    logic [DATA_W-1:0] instr_out  [2];
    logic [ADDR_W-1:0] instr_pc   [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .rstn(rstn), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready[0]),
        .imem_rd(imem_rd[0]), .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
        .instr_out(instr_out[0]), .instr_pc(instr_pc[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready), .flush(flush));

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .rstn(rstn), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready[1]),
        .imem_rd(imem_rd[1]), .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
        .instr_out(instr_out[1]), .instr_pc(instr_pc[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready), .flush(flush));

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Memory contents: a fixed, address-dependent word.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [11:0] lo;
        lo = 12'(a) * 12'd3 + 12'd1;
        return {a, ~a, lo};
    endfunction

    // Instruction memory models: delay line of read requests, junk when idle.
    logic              hist_v [2][3];
    logic [ADDR_W-1:0] hist_a [2][3];
    logic [DATA_W-1:0] junk   [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) begin
                hist_v[k][s] = 1'b0;
                hist_a[k][s] = '0;
            end
            junk[k] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            hist_v[k][0] <= imem_rd[k];
            hist_a[k][0] <= imem_addr[k];
            for (int s = 1; s < 3; s++) begin
                hist_v[k][s] <= hist_v[k][s-1];
                hist_a[k][s] <= hist_a[k][s-1];
            end
            junk[k] <= $urandom;
        end
    end

    always @* begin
        for (int k = 0; k < 2; k++) begin
            imem_rdata[k] = hist_v[k][lat_of(k)-1] ? mem_word(hist_a[k][lat_of(k)-1]) : junk[k];
        end
    end

    // Expectation log: every accepted PC in order, with the cycle it becomes visible.
    logic [ADDR_W-1:0] exp_pc  [2][LOGN];
    int                exp_rdy [2][LOGN];
    int                head [2] = '{0, 0};
    int                tail [2] = '{0, 0};

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lat%0d cyc=%0d: got %0h expected %0h", name, lat_of(k), cyc, act, exp);
        end
    endtask

    // Monitor: compare mid-cycle, then advance the reference for the coming edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit exp_ready;
            bit exp_valid;
            exp_ready = rstn && !flush && ((tail[k] - head[k]) < DEPTH);
            exp_valid = (head[k] < tail[k]) && (exp_rdy[k][head[k]] <= cyc);
            if (mon_en) begin
                chk("pc_ready", k, 64'(pc_ready[k]), 64'(exp_ready));
                chk("imem_rd", k, 64'(imem_rd[k]), 64'(pc_valid && exp_ready));
                if (pc_valid && exp_ready)
                    chk("imem_addr", k, 64'(imem_addr[k]), 64'(pc_addr));
                chk("instr_valid", k, 64'(instr_valid[k]), 64'(exp_valid));
                if (exp_valid) begin
                    chk("instr_pc", k, 64'(instr_pc[k]), 64'(exp_pc[k][head[k]]));
                    chk("instr_out", k, 64'(instr_out[k]), 64'(mem_word(exp_pc[k][head[k]])));
                end else begin
                    chk("instr_pc_idle", k, 64'(instr_pc[k]), 64'(0));
                    chk("instr_out_idle", k, 64'(instr_out[k]), 64'(0));
                end
            end
            if (!rstn || flush) begin
                head[k] = tail[k];
            end else begin
                if (exp_valid && instr_ready) head[k]++;
                if (pc_valid && exp_ready && tail[k] < LOGN) begin
                    exp_pc[k][tail[k]]  = pc_addr;
                    exp_rdy[k][tail[k]] = cyc + lat_of(k) + 1;
                    tail[k]++;
                end
            end
        end
        cyc++;
    end

    // Advance one cycle; the PC counter steps when the latency-1 unit accepted.
    task automatic tick();
        bit acc;
        #2 acc = pc_valid && pc_ready[0];
        @(posedge clk);
        #1;
        if (acc) pc_addr = pc_addr + ADDR_W'(1);
    endtask

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        pc_valid    = 1'b1;
        instr_ready = 1'b1;
        pc_addr     = ADDR_W'(7);
        @(posedge clk);
        #1 mon_en = 1'b1;
        // Reset held with pc_valid asserted.
        tick();
        tick();

        // Streaming from PC 0 with decode always ready.
        rstn    = 1'b1;
        pc_addr = '0;
        for (int i = 0; i < 10; i++) tick();

        // Backpressure: decode stalls until credit runs out, then drains.
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Flush with buffered and in-flight entries, then restart at 0x040.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1;
        tick();
        flush       = 1'b0;
        pc_addr     = ADDR_W'(12'h040);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Reset in the middle of traffic.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rstn = 1'b0;
        flush = 1'b1;
        tick();
        rstn  = 1'b1;
        flush = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Random sweep.
        for (int i = 0; i < 2000; i++) begin
            pc_valid    = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 49) == 0);
            rstn        = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 31) == 0) pc_addr = ADDR_W'($urandom);
            tick();
        end

        // Drain.
        rstn = 1'b1; flush = 1'b0; pc_valid = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
